// File: rtl/controlador_entrada_saida.sv
// IO responder for the CPU IN/OUT path: button-gated switch capture and
// sequential binary-to-BCD conversion for three seven-segment digits.
module controlador_entrada_saida #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IN_W      = 4,
    parameter int unsigned CONV_BITS = 10,
    parameter int unsigned MAX_DISP  = 999
) (
    input  logic              i_clk,
    input  logic              i_n_reset,
    input  logic              i_req_in,
    input  logic              i_req_out,
    input  logic [DATA_W-1:0] i_dado_saida,
    input  logic              i_botao,
    input  logic [IN_W-1:0]   i_chaves,
    output logic [DATA_W-1:0] o_dado_lido,
    output logic              o_pronto,
    output logic              o_ocupado,
    output logic              o_estouro,
    output logic [3:0]        o_unidade,
    output logic [3:0]        o_dezena,
    output logic [3:0]        o_centena
);

    localparam int unsigned CNT_W = $clog2(CONV_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_BITS);

    typedef enum logic [2:0] {
        StOcioso,
        StEsperaSolta,
        StEsperaAperto,
        StConverte,
        StConclui
    } state_e;

    state_e                r_state, w_state_d;
    logic [CONV_BITS-1:0]  r_shift, w_shift_d;
    logic [11:0]           r_bcd, w_bcd_d;
    logic [CNT_W-1:0]      r_cnt, w_cnt_d;
    logic                  r_botao_prev;
    logic [DATA_W-1:0]     r_dado_lido, w_dado_lido_d;
    logic                  r_estouro, w_estouro_d;
    logic [11:0]           r_digits, w_digits_d;

    logic                  w_over;
    logic [DATA_W-1:0]     w_val;
    logic [11:0]           w_bcd_adj;
    logic [11:0]           w_bcd_sh;
    logic [CONV_BITS-1:0]  w_shift_sh;

    assign w_over = i_dado_saida > DATA_W'(MAX_DISP);
    assign w_val  = w_over ? DATA_W'(MAX_DISP) : i_dado_saida;

    // Shift-add-3: correct every nibble >= 5 before the doubling shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_sh   = {w_bcd_adj[10:0], r_shift[CONV_BITS-1]};
    assign w_shift_sh = {r_shift[CONV_BITS-2:0], 1'b0};

    always_comb begin
        w_state_d     = r_state;
        w_shift_d     = r_shift;
        w_bcd_d       = r_bcd;
        w_cnt_d       = r_cnt;
        w_dado_lido_d = r_dado_lido;
        w_estouro_d   = r_estouro;
        w_digits_d    = r_digits;
        unique case (r_state)
            StOcioso: begin
                // OUT wins a collision; the simultaneous IN is dropped.
                if (i_req_out) begin
                    w_estouro_d = w_over;
                    w_shift_d   = w_val[CONV_BITS-1:0];
                    w_bcd_d     = '0;
                    w_cnt_d     = '0;
                    w_state_d   = StConverte;
                end else if (i_req_in) begin
                    w_state_d = i_botao ? StEsperaSolta : StEsperaAperto;
                end
            end
            StEsperaSolta: begin
                if (!i_botao) w_state_d = StEsperaAperto;
            end
            StEsperaAperto: begin
                if (i_botao && !r_botao_prev) begin
                    w_dado_lido_d = {{(DATA_W-IN_W){1'b0}}, i_chaves};
                    w_state_d     = StConclui;
                end
            end
            StConverte: begin
                if (r_cnt == CNT_LAST) begin
                    w_digits_d = r_bcd;
                    w_state_d  = StConclui;
                end else begin
                    w_bcd_d   = w_bcd_sh;
                    w_shift_d = w_shift_sh;
                    w_cnt_d   = r_cnt + CNT_W'(1);
                end
            end
            StConclui: w_state_d = StOcioso;
            default:   w_state_d = StOcioso;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_state      <= StOcioso;
            r_shift      <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_botao_prev <= 1'b0;
            r_dado_lido  <= '0;
            r_estouro    <= 1'b0;
            r_digits     <= '0;
        end else begin
            r_state      <= w_state_d;
            r_shift      <= w_shift_d;
            r_bcd        <= w_bcd_d;
            r_cnt        <= w_cnt_d;
            r_botao_prev <= i_botao;
            r_dado_lido  <= w_dado_lido_d;
            r_estouro    <= w_estouro_d;
            r_digits     <= w_digits_d;
        end
    end

    assign o_dado_lido = r_dado_lido;
    assign o_pronto    = (r_state == StConclui);
    assign o_ocupado   = (r_state != StOcioso);
    assign o_estouro   = r_estouro;
    assign o_centena   = r_digits[11:8];
    assign o_dezena    = r_digits[7:4];
    assign o_unidade   = r_digits[3:0];

endmodule
